// File: rtl/window_gen_3x3_pkg.sv
// Shared defaults and FSM state encoding for the 3x3 sliding-window generator.
package window_gen_3x3_pkg;

  localparam int unsigned DEF_IMG_W = 640;
  localparam int unsigned DEF_IMG_H = 480;
  localparam int unsigned DEF_N     = 8;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One-line delay: dout is the din presented DEPTH enables earlier.
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Contents are never reset; stale data is flushed by two full lines before use.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 window generator: two chained line buffers feed a shifting window.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned N     = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pix_in,
  input  logic         pix_valid,
  input  logic         sof,
  output logic [N-1:0] sw_pixel_1,
  output logic [N-1:0] sw_pixel_2,
  output logic [N-1:0] sw_pixel_3,
  output logic [N-1:0] sw_pixel_4,
  output logic [N-1:0] sw_pixel_5,
  output logic [N-1:0] sw_pixel_6,
  output logic [N-1:0] sw_pixel_7,
  output logic [N-1:0] sw_pixel_8,
  output logic [N-1:0] sw_pixel_9,
  output logic         act,
  output logic         frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d, cur_col;
  logic [RW-1:0]  row_q, row_d, cur_row;
  logic           act_q, act_d;
  logic           done_q, done_d;
  logic           accept, last_col, last_pix;
  logic [N-1:0]   lb1_out, lb2_out;
  logic [N-1:0]   win_q [3][3];

  line_buffer #(.DEPTH(IMG_W), .WIDTH(N)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (pix_in),
    .dout (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(N)) u_lb2 (
    .clk  (clk),
    .en   (accept),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    act_d    = 1'b0;
    done_d   = 1'b0;
    accept   = pix_valid && (sof || (state_q == ACTIVE));
    // sof re-anchors the accepted pixel at (0,0) in either state.
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_pix = last_col && (cur_row == RW'(IMG_H - 1));
    if (accept) begin
      act_d   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      done_d  = last_pix;
      state_d = last_pix ? WAIT_SOF : ACTIVE;
      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SOF;
      col_q   <= '0;
      row_q   <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      act_q   <= act_d;
      done_q  <= done_d;
      if (accept) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_out;
        win_q[1][2] <= lb1_out;
        win_q[2][2] <= pix_in;
      end
    end
  end

  assign sw_pixel_1 = win_q[0][0];
  assign sw_pixel_2 = win_q[0][1];
  assign sw_pixel_3 = win_q[0][2];
  assign sw_pixel_4 = win_q[1][0];
  assign sw_pixel_5 = win_q[1][1];
  assign sw_pixel_6 = win_q[1][2];
  assign sw_pixel_7 = win_q[2][0];
  assign sw_pixel_8 = win_q[2][1];
  assign sw_pixel_9 = win_q[2][2];
  assign act        = act_q;
  assign frame_done = done_q;

endmodule
